div_iter: RTL and testbench

- Parametrised multi-cycle integer divider for the EX stage. Serves DIV and DIVU, the decoder ops that raise HLwrite.
- Restoring radix-2 algorithm on operand magnitudes, one quotient bit per cycle.
- Start/ready handshake, busy indication for pipeline stall, annul input for flush/exception.
- Result is packed {remainder, quotient}, ready to load into HI/LO.

---
 rtl/div_iter.sv | 162 ++++++++++++++++
 tb/tb_div_iter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU in EX; one quotient bit per cycle.
// Result is packed {remainder, quotient} so it can be loaded straight into {HI, LO}.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dividend_raw;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_quo;
    logic               neg_rem;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_n;
    logic [WIDTH-1:0]   quo_n;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = (state == IDLE) && start && !annul;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    assign busy  = (state == DIVZERO) || (state == ON);
    assign ready = (state == END);

    // The core works on magnitudes; signs are reapplied only once, on the final iteration.
    always_comb begin
        dividend_mag = opdata1;
        divisor_mag  = opdata2;
        if (signed_div && opdata1[WIDTH-1]) begin
            dividend_mag = ~opdata1 + 1'b1;
        end
        if (signed_div && opdata2[WIDTH-1]) begin
            divisor_mag = ~opdata2 + 1'b1;
        end
    end

    // The partial remainder is always below the divisor, so one extra bit holds the shifted trial value.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = ~diff[WIDTH];
        rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_n   = {quo_q[WIDTH-2:0], ge};
        quo_fix = neg_quo ? (~quo_n + 1'b1) : quo_n;
        rem_fix = neg_rem ? (~rem_n + 1'b1) : rem_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start && !annul) begin
                    state_nx = (opdata2 == '0) ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                state_nx = annul ? IDLE : END;
            end
            ON: begin
                if (annul) begin
                    state_nx = IDLE;
                end else if (last_iter) begin
                    state_nx = END;
                end
            end
            END: begin
                state_nx = start ? END : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // result is written only on the way into END, so it holds across IDLE and annulled operations.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            result       <= '0;
            dividend_raw <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dividend_raw <= opdata1;
                        quo_q        <= dividend_mag;
                        rem_q        <= '0;
                        dvs_q        <= divisor_mag;
                        neg_quo      <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_rem      <= signed_div & opdata1[WIDTH-1];
                        cnt          <= '0;
                    end
                end
                DIVZERO: begin
                    if (annul) begin
                        cnt <= '0;
                    end else begin
                        result <= {dividend_raw, {WIDTH{1'b1}}};
                    end
                end
                ON: begin
                    if (annul) begin
                        cnt <= '0;
                    end else begin
                        quo_q <= quo_n;
                        rem_q <= rem_n;
                        cnt   <= cnt + 1'b1;
                        if (last_iter) begin
                            result <= {rem_fix, quo_fix};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: 32-bit and 8-bit instances checked against a behavioural division model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;

    logic        start32, sd32, annul32;
    logic [31:0] a32, b32;
    logic [63:0] result32;
    logic        ready32, busy32;

    logic        start8, sd8, annul8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;
    logic        ready8, busy8;

    logic [63:0] sb32[$];
    logic [63:0] sb8[$];
    logic [63:0] lastRes32;
    int          checkCount = 0;
    int          passCount  = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_div(sd32), .annul(annul32),
        .opdata1(a32), .opdata2(b32), .result(result32), .ready(ready32), .busy(busy32)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_div(sd8), .annul(annul8),
        .opdata1(a8), .opdata2(b8), .result(result8), .ready(ready8), .busy(busy8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {remainder, quotient} in 32-bit halves; narrower widths use the low w bits of each.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sd, input int w);
        logic [31:0] ax, bx, q, r;
        if (w == 8) begin
            ax = sd ? {{24{a[7]}}, a[7:0]} : {24'b0, a[7:0]};
            bx = sd ? {{24{b[7]}}, b[7:0]} : {24'b0, b[7:0]};
        end else begin
            ax = a;
            bx = b;
        end
        if (bx == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (sd && ax == 32'h80000000 && bx == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else if (sd) begin
            q = $signed(ax) / $signed(bx);
            r = $signed(ax) % $signed(bx);
        end else begin
            q = ax / bx;
            r = ax % bx;
        end
        return {r, q};
    endfunction

    task automatic applyStimulus(input bit w8, input logic [31:0] a, input logic [31:0] b,
                                 input logic sd, input int hold);
        logic [63:0] m, exp, got;
        int          edges, busyN, w;
        logic        rdy, bzero;
        w     = w8 ? 8 : 32;
        bzero = w8 ? (b[7:0] == 8'd0) : (b == 32'd0);
        m     = model(a, b, sd, w);
        if (w8) sb8.push_back({48'b0, m[39:32], m[7:0]});
        else    sb32.push_back(m);

        @(negedge clk);
        if (w8) begin a8 = a[7:0]; b8 = b[7:0]; sd8 = sd; start8 = 1'b1; end
        else    begin a32 = a; b32 = b; sd32 = sd; start32 = 1'b1; end
        edges = 0;
        busyN = 0;
        rdy   = 1'b0;
        while (!rdy && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            rdy = w8 ? ready8 : ready32;
            if (w8 ? busy8 : busy32) busyN++;
            // Operands after acceptance must not matter.
            if (w8) begin a8 = 8'($urandom); b8 = 8'($urandom); sd8 = ~sd; end
            else    begin a32 = $urandom; b32 = $urandom; sd32 = ~sd; end
        end
        checkOutput("latency", 64'(edges), bzero ? 64'd2 : 64'(w + 1));
        checkOutput("busy_cycles", 64'(busyN), bzero ? 64'd1 : 64'(w));
        exp = w8 ? sb8.pop_front() : sb32.pop_front();
        got = w8 ? {48'b0, result8} : result32;
        checkOutput("result", got, exp);
        if (!w8) lastRes32 = exp;

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_ready", 64'(w8 ? ready8 : ready32), 64'd1);
            checkOutput("hold_result", w8 ? {48'b0, result8} : result32, exp);
        end

        if (w8) start8 = 1'b0; else start32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_drop", 64'(w8 ? ready8 : ready32), 64'd0);
        checkOutput("result_idle", w8 ? {48'b0, result8} : result32, exp);
    endtask

    initial begin
        logic readySeen;
        rst = 1'b0;
        start32 = 1'b0; sd32 = 1'b0; annul32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; sd8  = 1'b0; annul8  = 1'b0; a8  = '0; b8  = '0;
        lastRes32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_result32", result32, 64'd0);
        checkOutput("reset_ready32", 64'(ready32), 64'd0);
        checkOutput("reset_busy32", 64'(busy32), 64'd0);
        checkOutput("reset_result8", {48'b0, result8}, 64'd0);
        rst = 1'b1;

        applyStimulus(1'b0, 32'd100, 32'd7, 1'b0, 0);
        applyStimulus(1'b0, 32'hFFFFFFF9, 32'h2, 1'b1, 0);
        applyStimulus(1'b0, 32'h7, 32'hFFFFFFFE, 1'b1, 0);
        applyStimulus(1'b0, 32'd5, 32'd0, 1'b0, 0);
        applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, $urandom, $urandom_range(1, 32'h0000FFFF), 1'($urandom), 0);
        end

        // Annul on the 10th ON cycle: back to IDLE, result untouched, no ready.
        @(negedge clk);
        a32 = 32'd100; b32 = 32'd7; sd32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (9) begin @(posedge clk); @(negedge clk); end
        annul32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("annul_busy", 64'(busy32), 64'd0);
        checkOutput("annul_ready", 64'(ready32), 64'd0);
        checkOutput("annul_result", result32, lastRes32);
        start32 = 1'b0;
        annul32 = 1'b0;
        readySeen = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); readySeen |= ready32 | busy32; end
        checkOutput("annul_quiet", 64'(readySeen), 64'd0);

        // Reset mid-operation clears every output on the next edge.
        a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_result", result32, 64'd0);
        checkOutput("midreset_ready", 64'(ready32), 64'd0);
        checkOutput("midreset_busy", 64'(busy32), 64'd0);
        start32 = 1'b0;
        rst = 1'b1;
        lastRes32 = '0;

        applyStimulus(1'b1, 32'd200, 32'd3, 1'b0, 5);
        applyStimulus(1'b1, 32'h80, 32'hFF, 1'b1, 0);
        applyStimulus(1'b1, 32'h9C, 32'h0, 1'b1, 0);
        applyStimulus(1'b1, 32'hF3, 32'h05, 1'b1, 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, $urandom, $urandom_range(1, 255), 1'($urandom), 0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
